arith_res_station: RTL

Reservation station for arithmetic-class ops (ARITH, LUI, AUIPC, BRANCH, JAL, JALR) in the Tomasulo core. It sits between the instruction-queue/issue stage and the ALU. It holds up to DEPTH issued instructions and snoops the common data bus for missing operands. When both operands of an entry are valid, it dispatches that entry to the ALU as an `alu_word` through a registered valid/ready output.

---
 rtl/tomasula_types.sv | 55 +++++
 rtl/rs_prio_enc.sv | 22 ++
 rtl/arith_res_station.sv | 119 +++++++++++
 3 files changed

// File: rtl/tomasula_types.sv
// Shared Tomasulo types: op classes, reservation-station issue word and ALU dispatch word.
package tomasula_types;

    localparam int TAG_W = 3;

    typedef enum logic [2:0] {
        OP_ARITH  = 3'd0,
        OP_LUI    = 3'd1,
        OP_AUIPC  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JAL    = 3'd4,
        OP_JALR   = 3'd5,
        OP_LOAD   = 3'd6,
        OP_STORE  = 3'd7
    } op_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             valid;
    } src_t;

    typedef struct packed {
        op_t              op;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        src_t             src1;
        src_t             src2;
        logic [TAG_W-1:0] rd_tag;
        logic [31:0]      pc;
    } res_word;

    typedef struct packed {
        op_t              op;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [31:0]      src1_data;
        logic [31:0]      src2_data;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
    } alu_word;

    function automatic alu_word to_alu_word(input res_word w);
        alu_word a;
        a.op        = w.op;
        a.funct3    = w.funct3;
        a.funct7    = w.funct7;
        a.src1_data = w.src1.data;
        a.src2_data = w.src2.data;
        a.pc        = w.pc;
        a.tag       = w.rd_tag;
        return a;
    endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-set-bit priority encoder; found=0 leaves index at zero.
module rs_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = i[$clog2(N)-1:0];
            end
        end
    end

endmodule

// File: rtl/arith_res_station.sv
// Arithmetic-class reservation station: holds issued ops, snoops the CDB for missing
// operands and hands the lowest-index ready entry to the ALU through a registered valid/ready port.
module arith_res_station
    import tomasula_types::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = tomasula_types::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  res_word          issue_word,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             alu_valid,
    input  logic             alu_ready,
    output alu_word          alu_out
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] busy;
    res_word          entry [DEPTH];
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] ready_vec;
    logic             free_found;
    logic             rdy_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] rdy_idx;
    logic             load_en;
    logic             issue_fire;
    logic             dispatch;
    res_word          issue_byp;

    // One tag comparator per source: wakes a waiting operand with the broadcast value.
    function automatic src_t snoop(input src_t s, input logic v,
                                   input logic [TAG_W-1:0] t, input logic [31:0] d);
        src_t r;
        r = s;
        if (!s.valid && v && (s.tag == t)) begin
            r.valid = 1'b1;
            r.data  = d;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = busy[i] && entry[i].src1.valid && entry[i].src2.valid;
        end
    end

    assign free_vec = ~busy;

    rs_prio_enc #(.N(DEPTH)) u_free_enc (
        .req   (free_vec),
        .found (free_found),
        .index (free_idx)
    );

    rs_prio_enc #(.N(DEPTH)) u_ready_enc (
        .req   (ready_vec),
        .found (rdy_found),
        .index (rdy_idx)
    );

    // A slot freed by this cycle's dispatch only shows up as free next cycle.
    assign issue_ready = free_found;
    assign issue_fire  = issue_valid && issue_ready;
    assign load_en     = !alu_valid || alu_ready;
    assign dispatch    = load_en && rdy_found;

    // Catch a broadcast that lands in the same cycle the consumer is issued.
    always_comb begin
        issue_byp      = issue_word;
        issue_byp.src1 = snoop(issue_word.src1, cdb_valid, cdb_tag, cdb_data);
        issue_byp.src2 = snoop(issue_word.src2, cdb_valid, cdb_tag, cdb_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            alu_valid <= 1'b0;
            alu_out   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (flush) begin
            busy      <= '0;
            alu_valid <= 1'b0;
            alu_out   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i]) begin
                    entry[i].src1 <= snoop(entry[i].src1, cdb_valid, cdb_tag, cdb_data);
                    entry[i].src2 <= snoop(entry[i].src2, cdb_valid, cdb_tag, cdb_data);
                end
            end
            // Issue targets a non-busy slot and dispatch a busy one, so they never collide.
            if (dispatch) begin
                busy[rdy_idx] <= 1'b0;
            end
            if (issue_fire) begin
                busy[free_idx]  <= 1'b1;
                entry[free_idx] <= issue_byp;
            end
            if (load_en) begin
                alu_valid <= rdy_found;
                if (rdy_found) begin
                    alu_out <= to_alu_word(entry[rdy_idx]);
                end
            end
        end
    end

endmodule
